// File: rtl/cu_pipe_ctrl.sv
// LA32R decode-stage control: decodes ID, launches the EX bundle, stalls ID on RAW hazards.
// Optional macro CU_FWD_EN: forwarding exists downstream, so only load-use hazards stall.

`ifndef ALU_ADD
`define ALU_ADD      5'd0
`define ALU_SUB      5'd1
`define ALU_AND      5'd2
`define ALU_OR       5'd3
`define ALU_XOR      5'd4
`define ALU_NOR      5'd5
`define ALU_SLL      5'd6
`define ALU_SRL      5'd7
`define ALU_SRA      5'd8
`define ALU_SLT      5'd9
`define ALU_SLTU     5'd10
`define ALU_LUI      5'd11
`define EXT_NONE     3'd0
`define EXT_SI12     3'd1
`define EXT_UI12     3'd2
`define EXT_SI20     3'd3
`define RAM_EXT_NONE 3'd0
`define RAM_EXT_B    3'd1
`define RAM_EXT_BU   3'd2
`define RAM_EXT_H    3'd3
`define RAM_EXT_HU   3'd4
`define RAM_EXT_W    3'd5
`define WD_ALU       2'd0
`define WD_RAM       2'd1
`define WD_PC4       2'd2
`define ALUA_PC      1'b0
`define ALUA_R1      1'b1
`define ALUB_R2      1'b0
`define ALUB_EXT     1'b1
`endif

module cu_pipe_ctrl #(
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned REG_AW     = 5
) (
   input  logic              cpu_clk,
   input  logic              cpu_rstn,
   input  logic              id_valid,
   input  logic [31:0]       id_inst,
   output logic              id_ready,
   input  logic              ex_ready,
   input  logic              flush,
   output logic              ex_valid,
   output logic [4:0]        ex_alu_op,
   output logic [2:0]        ex_ext_op,
   output logic [2:0]        ex_ram_ext_op,
   output logic [3:0]        ex_ram_we,
   output logic              ex_rf_we,
   output logic [1:0]        ex_wd_sel,
   output logic              ex_alua_sel,
   output logic              ex_alub_sel,
   output logic [REG_AW-1:0] ex_wr_addr,
   output logic              ex_ine
);

   typedef struct packed {
      logic [4:0]        alu_op;
      logic [2:0]        ext_op;
      logic [2:0]        ram_ext_op;
      logic [3:0]        ram_we;
      logic              rf_we;
      logic [1:0]        wd_sel;
      logic              alua_sel;
      logic              alub_sel;
      logic [REG_AW-1:0] wr_addr;
      logic              ine;
   } bundle_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] wr_addr;
      logic              is_load;
   } sb_t;

   bundle_t                dec;
   bundle_t                bnd_q, bnd_d;
   logic                   ex_valid_q, ex_valid_d;
   sb_t [PIPE_DEPTH-1:0]   sb_q, sb_d;
   logic                   use_rj, use_rk, use_rd, dec_load, known;
   logic                   hazard, issue;
   logic [16:0]            op3r;
   logic [9:0]             op12;
   logic [6:0]             op20;
   logic [REG_AW-1:0]      src_j, src_k, src_d;

   assign op3r  = id_inst[31:15];
   assign op12  = id_inst[31:22];
   assign op20  = id_inst[31:25];
   assign src_d = REG_AW'(id_inst[4:0]);
   assign src_j = REG_AW'(id_inst[9:5]);
   assign src_k = REG_AW'(id_inst[14:10]);

   // Instruction decode into the EX bundle plus source-read flags.
   always_comb begin
      dec          = '0;
      dec.alu_op   = `ALU_ADD;
      dec.ext_op   = `EXT_SI12;
      dec.alua_sel = `ALUA_R1;
      dec.alub_sel = `ALUB_EXT;
      dec.rf_we    = 1'b1;
      dec.wd_sel   = `WD_ALU;
      dec.wr_addr  = src_d;
      use_rj       = 1'b1;
      use_rk       = 1'b0;
      use_rd       = 1'b0;
      dec_load     = 1'b0;
      known        = 1'b1;
      if (op12 == 10'h000) begin
         dec.ext_op   = `EXT_NONE;
         dec.alub_sel = `ALUB_R2;
         use_rk       = 1'b1;
         case (op3r)
            17'h00020: dec.alu_op = `ALU_ADD;
            17'h00022: dec.alu_op = `ALU_SUB;
            17'h00024: dec.alu_op = `ALU_SLT;
            17'h00025: dec.alu_op = `ALU_SLTU;
            17'h00028: dec.alu_op = `ALU_NOR;
            17'h00029: dec.alu_op = `ALU_AND;
            17'h0002A: dec.alu_op = `ALU_OR;
            17'h0002B: dec.alu_op = `ALU_XOR;
            17'h0002E: dec.alu_op = `ALU_SLL;
            17'h0002F: dec.alu_op = `ALU_SRL;
            17'h00030: dec.alu_op = `ALU_SRA;
            default:   known      = 1'b0;
         endcase
      end else if (op20 == 7'h0A || op20 == 7'h0E) begin
         use_rj     = 1'b0;
         dec.ext_op = `EXT_SI20;
         if (op20 == 7'h0A) dec.alu_op   = `ALU_LUI;
         else               dec.alua_sel = `ALUA_PC;
      end else begin
         case (op12)
            10'h008: dec.alu_op = `ALU_SLT;
            10'h009: dec.alu_op = `ALU_SLTU;
            10'h00A: dec.alu_op = `ALU_ADD;
            10'h00D: begin dec.alu_op = `ALU_AND; dec.ext_op = `EXT_UI12; end
            10'h00E: begin dec.alu_op = `ALU_OR;  dec.ext_op = `EXT_UI12; end
            10'h00F: begin dec.alu_op = `ALU_XOR; dec.ext_op = `EXT_UI12; end
            10'h0A0: begin dec_load = 1'b1; dec.wd_sel = `WD_RAM; dec.ram_ext_op = `RAM_EXT_B;  end
            10'h0A8: begin dec_load = 1'b1; dec.wd_sel = `WD_RAM; dec.ram_ext_op = `RAM_EXT_BU; end
            10'h0A1: begin dec_load = 1'b1; dec.wd_sel = `WD_RAM; dec.ram_ext_op = `RAM_EXT_H;  end
            10'h0A9: begin dec_load = 1'b1; dec.wd_sel = `WD_RAM; dec.ram_ext_op = `RAM_EXT_HU; end
            10'h0A2: begin dec_load = 1'b1; dec.wd_sel = `WD_RAM; dec.ram_ext_op = `RAM_EXT_W;  end
            10'h0A4: begin dec.rf_we = 1'b0; use_rd = 1'b1; dec.ram_we = 4'b0001; end
            10'h0A5: begin dec.rf_we = 1'b0; use_rd = 1'b1; dec.ram_we = 4'b0011; end
            10'h0A6: begin dec.rf_we = 1'b0; use_rd = 1'b1; dec.ram_we = 4'b1111; end
            default: known = 1'b0;
         endcase
      end
      if (!dec.rf_we) dec.wr_addr = '0;
      if (!known) begin
         dec        = '0;
         dec.alu_op = `ALU_ADD;
         dec.ine    = 1'b1;
         use_rj     = 1'b0;
         use_rk     = 1'b0;
         use_rd     = 1'b0;
         dec_load   = 1'b0;
      end
   end

   // RAW detection against in-flight destinations; r0 destinations never match.
   always_comb begin
      hazard = 1'b0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
         logic live;
         live = sb_q[k].v && (sb_q[k].wr_addr != '0);
`ifdef CU_FWD_EN
         live = live && (k == 0) && sb_q[k].is_load;
`endif
         if (live && ((use_rj && sb_q[k].wr_addr == src_j) ||
                      (use_rk && sb_q[k].wr_addr == src_k) ||
                      (use_rd && sb_q[k].wr_addr == src_d)))
            hazard = 1'b1;
      end
   end

   assign id_ready = ex_ready & ~hazard & ~flush;
   assign issue    = id_valid & id_ready;

   // ID/EX and scoreboard advance together only when EX accepts.
   always_comb begin
      ex_valid_d = ex_valid_q;
      bnd_d      = bnd_q;
      sb_d       = sb_q;
      if (ex_ready) begin
         ex_valid_d = issue;
         bnd_d      = issue ? dec : '0;
         for (int unsigned k = 1; k < PIPE_DEPTH; k++) sb_d[k] = sb_q[k-1];
         sb_d[0].v       = issue;
         sb_d[0].wr_addr = issue ? dec.wr_addr : '0;
         sb_d[0].is_load = issue & dec_load;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         ex_valid_q <= 1'b0;
         bnd_q      <= '0;
         sb_q       <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         bnd_q      <= bnd_d;
         sb_q       <= sb_d;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_alu_op     = bnd_q.alu_op;
   assign ex_ext_op     = bnd_q.ext_op;
   assign ex_ram_ext_op = bnd_q.ram_ext_op;
   assign ex_ram_we     = bnd_q.ram_we;
   assign ex_rf_we      = bnd_q.rf_we;
   assign ex_wd_sel     = bnd_q.wd_sel;
   assign ex_alua_sel   = bnd_q.alua_sel;
   assign ex_alub_sel   = bnd_q.alub_sel;
   assign ex_wr_addr    = bnd_q.wr_addr;
   assign ex_ine        = bnd_q.ine;

endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// Scoreboard bench for cu_pipe_ctrl: expected bundles queued at issue, compared when EX receives them.
// Stall expectations follow CU_FWD_EN and the default PIPE_DEPTH of 3.

module tb_cu_pipe_ctrl;

   logic        cpu_clk, cpu_rstn;
   logic        id_valid, id_ready, ex_ready, flush;
   logic [31:0] id_inst;
   logic        ex_valid, ex_rf_we, ex_alua_sel, ex_alub_sel, ex_ine;
   logic [4:0]  ex_alu_op, ex_wr_addr;
   logic [2:0]  ex_ext_op, ex_ram_ext_op;
   logic [3:0]  ex_ram_we;
   logic [1:0]  ex_wd_sel;

   cu_pipe_ctrl #(.PIPE_DEPTH(3), .REG_AW(5)) dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .id_valid(id_valid), .id_inst(id_inst), .id_ready(id_ready),
      .ex_ready(ex_ready), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_ext_op(ex_ext_op),
      .ex_ram_ext_op(ex_ram_ext_op), .ex_ram_we(ex_ram_we), .ex_rf_we(ex_rf_we),
      .ex_wd_sel(ex_wd_sel), .ex_alua_sel(ex_alua_sel), .ex_alub_sel(ex_alub_sel),
      .ex_wr_addr(ex_wr_addr), .ex_ine(ex_ine)
   );

`ifdef CU_FWD_EN
   localparam int LD_STALL = 1, DEP_STALL = 0, HOLD_STALL = 0;
`else
   localparam int LD_STALL = 3, DEP_STALL = 3, HOLD_STALL = 2;
`endif
   localparam logic [31:0] M_ALL = 32'h03FF_FFFF;

   typedef struct {
      logic [31:0] v;
      logic [31:0] m;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0, n_fail = 0;
   logic        last_acc, last_rdy;
   logic [31:0] cur_exp, cur_mask;

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] alu, input logic [2:0] ext,
                                      input logic [2:0] rext, input logic [3:0] rwe,
                                      input logic rfwe, input logic [1:0] wd, input logic a,
                                      input logic b, input logic [4:0] wr, input logic ine);
      return {6'd0, alu, ext, rext, rwe, rfwe, wd, a, b, wr, ine};
   endfunction

   function automatic logic [31:0] dut_pack();
      return {6'd0, ex_alu_op, ex_ext_op, ex_ram_ext_op, ex_ram_we, ex_rf_we, ex_wd_sel,
              ex_alua_sel, ex_alub_sel, ex_wr_addr, ex_ine};
   endfunction

   // One clock: inputs were set just after a negedge; ends at the following negedge.
   task automatic step();
      logic exp_v, rdy_now;
      exp_t e;
      #1;
      rdy_now  = ex_ready;
      last_rdy = id_ready;
      last_acc = id_valid && id_ready;
      exp_v    = rdy_now ? last_acc : ex_valid;
      if (last_acc) begin
         e.v = cur_exp;
         e.m = cur_mask;
         exp_q.push_back(e);
      end
      @(posedge cpu_clk);
      #1;
      check("ex_valid", 32'(ex_valid), 32'(exp_v));
      if (rdy_now && ex_valid) begin
         if (exp_q.size() == 0) check("unexpected_bundle", 32'(1), 32'(0));
         else begin
            e = exp_q.pop_front();
            check("bundle", dut_pack() & e.m, e.v & e.m);
         end
      end
      @(negedge cpu_clk);
   endtask

   task automatic issue(input string tag, input logic [31:0] inst, input logic [31:0] exp,
                        input logic [31:0] mask, input int exp_stalls);
      int  stalls;
      bit  done;
      stalls   = 0;
      done     = 0;
      cur_exp  = exp;
      cur_mask = mask;
      id_valid = 1'b1;
      id_inst  = inst;
      ex_ready = 1'b1;
      flush    = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         if (last_acc) done = 1;
         else stalls++;
      end
      check({tag, "_accepted"}, 32'(done), 32'(1));
      check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      id_valid = 1'b0;
   endtask

   initial begin
      cpu_rstn = 1'b0;
      id_valid = 1'b0;
      id_inst  = 32'h0;
      ex_ready = 1'b1;
      flush    = 1'b0;
      cur_exp  = '0;
      cur_mask = '0;
      #3;
      check("rst_ex_valid", 32'(ex_valid), 32'(0));
      check("rst_bundle", dut_pack(), 32'h0);
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      #1;
      check("rst_id_ready", 32'(id_ready), 32'(1));

      issue("or_r1",      32'h00150C41, mk(5'd3, 3'd0, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd1, 1'b0), M_ALL, 0);
      issue("ldw_r4",     32'h288000A4, mk(5'd0, 3'd1, 3'd5, 4'h0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd4, 1'b0), M_ALL, 0);
      issue("add_r6_lu",  32'h00101086, mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd6, 1'b0), M_ALL, LD_STALL);
      issue("stw_r7",     32'h29801107, mk(5'd0, 3'd1, 3'd0, 4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 5'd0, 1'b0), M_ALL, 0);
      issue("add_r9_r7",  32'h00101CE9, mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd9, 1'b0), M_ALL, 0);
      issue("pcadd_r10",  32'h1C00002A, mk(5'd0, 3'd3, 3'd0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd10, 1'b0), M_ALL, 0);
      issue("lu12i_r11",  32'h142468AB, mk(5'd11, 3'd3, 3'd0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd11, 1'b0),
            M_ALL & ~mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0), 0);
      issue("ori_r12",    32'h0383FC0C, mk(5'd3, 3'd2, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b1, 5'd12, 1'b0), M_ALL, 0);
      issue("stb_r13",    32'h2900002D, mk(5'd0, 3'd1, 3'd0, 4'h1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd0, 1'b0), M_ALL, 0);
      issue("ori_r14",    32'h0380040E, mk(5'd3, 3'd2, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b1, 5'd14, 1'b0), M_ALL, 0);
      issue("add_r15_dep",32'h001001CF, mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd15, 1'b0), M_ALL, DEP_STALL);

      // Flush squashes the ID instruction, then EX back-pressure freezes everything.
      id_valid = 1'b1;
      id_inst  = 32'h00150C41;
      flush    = 1'b1;
      ex_ready = 1'b1;
      step();
      check("flush_id_ready", 32'(last_rdy), 32'(0));
      flush    = 1'b0;
      ex_ready = 1'b0;
      id_inst  = 32'h001001F0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("hold_id_ready", 32'(last_rdy), 32'(0));
      end
      issue("add_r16_r15",32'h001001F0, mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd16, 1'b0), M_ALL, HOLD_STALL);

      issue("unknown",    32'hFFFFFFFF, mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1),
            mk(5'h1F, 3'd0, 3'd0, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1), 0);

      // Reset in the middle of a back-pressure stall with a load in EX.
      issue("ldw_r4_b",   32'h288000A4, mk(5'd0, 3'd1, 3'd5, 4'h0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd4, 1'b0), M_ALL, 0);
      id_valid = 1'b1;
      id_inst  = 32'h00101086;
      ex_ready = 1'b0;
      step();
      check("stall_id_ready", 32'(last_rdy), 32'(0));
      check("stall_bundle", dut_pack(), mk(5'd0, 3'd1, 3'd5, 4'h0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd4, 1'b0));
      #2;
      cpu_rstn = 1'b0;
      #1;
      check("async_rst_valid", 32'(ex_valid), 32'(0));
      check("async_rst_bundle", dut_pack(), 32'h0);
      check("queue_before_rst", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      ex_ready = 1'b1;
      #1;
      check("post_rst_id_ready", 32'(id_ready), 32'(1));
      @(negedge cpu_clk);
      issue("add_r6_clr", 32'h00101086, mk(5'd0, 3'd0, 3'd0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd6, 1'b0), M_ALL, 0);

      step();
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cu_pipe_ctrl.md
Name: cu_pipe_ctrl

Overview:
Registered decode-stage control unit for the LA32R pipeline. It decodes the ID-stage instruction into the EX control bundle and launches it into a one-entry ID/EX register under a valid/ready handshake. An internal scoreboard tracks the destination registers of in-flight instructions and detects RAW hazards, holding ID when one exists. Branch flushes from EX insert bubbles.

Parameters:
PIPE_DEPTH, 3, number of downstream stages tracked by the scoreboard (EX, MEM, WB); legal range 1..4
REG_AW, 5, register index width

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rstn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds an instruction
id_inst  in  32  ID instruction word
id_ready  out  1  ID instruction accepted this cycle; combinational
ex_ready  in  1  EX can accept; when low, ID/EX and scoreboard hold
flush  in  1  branch/jump taken in EX; squash the ID instruction
ex_valid  out  1  ID/EX bundle valid
ex_alu_op  out  5  ALU operation, `ALU_* encodings
ex_ext_op  out  3  immediate extension, `EXT_* encodings
ex_ram_ext_op  out  3  load extension, `RAM_EXT_* encodings
ex_ram_we  out  4  store byte enables, unshifted
ex_rf_we  out  1  writeback enable
ex_wd_sel  out  2  writeback source, `WD_* encodings
ex_alua_sel  out  1  `ALUA_PC / `ALUA_R1
ex_alub_sel  out  1  `ALUB_R2 / `ALUB_EXT
ex_wr_addr  out  REG_AW  destination register; forced to 0 when rf_we=0
ex_ine  out  1  instruction not in the decode set

Behaviour:
- Reset: all ex_* outputs 0. The scoreboard clears to invalid. id_ready follows its equation.
- Decode set:
  - 3R: add.w, sub.w, and, or, xor, nor, sll.w, srl.w, sra.w, slt, sltu.
  - 2RI12: addi.w, slti, sltui, andi, ori, xori, ld.b/bu/h/hu/w, st.b/h/w.
  - 1RI20: lu12i.w, pcaddu12i (alua=PC).
- Source-register reads:
  - rj is read by all except the 1RI20 forms.
  - rk is read by 3R.
  - rd is read as source 2 by stores.
- Store byte enables: st.b=0001, st.h=0011, st.w=1111. Stores have rf_we=0.
- Unknown encodings: bundle issues with ex_valid=1, ex_ine=1, rf_we=0, ram_we=0, alu_op=`ALU_ADD.
- Scoreboard:
  - Entries sb[0..PIPE_DEPTH-1], each holding {v, wr_addr, is_load}. sb[0] mirrors the ID/EX register.
  - When ex_ready=1, the scoreboard shifts: sb[k+1]<=sb[k], and sb[0] takes the issued bundle, or a bubble (v=0).
  - When ex_ready=0, everything holds.
- Hazard:
  - A match requires: the source is read, source index != 0, sb[k].v=1, and sb[k].wr_addr equals the source index.
  - The macro section below decides which k values count.
- Handshake:
  - id_ready = ex_ready & ~hazard & ~flush.
  - Issue = id_valid & id_ready; the bundle is registered the same edge, for 1-cycle latency.
  - On a hazard with ex_ready=1, a bubble enters EX.
- Flush has priority over issue: the ID/EX register takes a bubble and id_ready=0. In-flight scoreboard entries are kept, because they are older than the branch.
- Flush while ex_ready=0 has no effect; EX must hold flush until ex_ready.
- r0: writes to r0 are recorded with wr_addr=0 and never match.
- Reset mid-stream: the asynchronous clear discards the bundle and all entries immediately.

Optional Feature:
CU_FWD_EN
- Defined: EX/MEM/WB forwarding exists. Only load-use stalls: a match on sb[0] with is_load=1. Other entries are ignored.
- Undefined: no forwarding. A match on any sb[k], k<PIPE_DEPTH, stalls.

Test Plan:
- Reset then issue 0x00150C41 (or r1,r2,r3) with ex_ready=1 -> next cycle: ex_valid=1, ex_alu_op=`ALU_OR, ex_wr_addr=1, ex_rf_we=1, ex_alub_sel=`ALUB_R2.
- ld.w r4,r5,0 (0x288000A4) then add.w r6,r4,r4 (0x00101086), CU_FWD_EN defined -> add held 1 cycle (id_ready=0, one bubble), then issued.
- Same sequence, CU_FWD_EN undefined, PIPE_DEPTH=3 -> add held 3 cycles, with 3 bubbles.
- st.w r7,r8,4 (0x29801107) -> ex_ram_we=1111, ex_rf_we=0, ex_wr_addr=0, ex_alub_sel=`ALUB_EXT. A following read of r7 does not stall.
- flush=1 with id_valid=1 -> id_ready=0 and ex_valid=0 next cycle. Then ex_ready=0 for 2 cycles -> all outputs and the scoreboard are unchanged.
- id_inst=0xFFFFFFFF -> ex_ine=1, ex_rf_we=0. Drop cpu_rstn mid-stall -> ex_valid=0 at once and id_ready=1 after release.
